// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Writer side of the instruction memory. Takes a big-endian byte stream,
// packs every four bytes into one instruction word and writes the words to
// consecutive byte addresses BASE_ADDR, BASE_ADDR+4, ... `busy` stays high
// for the whole load so the core can be held off.
//
// Optional feature (compile-time macro): LOADER_CHECKSUM_EN
//   When defined, an 8-bit running sum of every instruction byte is kept.
//   After the last write one extra byte is accepted and compared with that
//   sum. A mismatch ends the load with error=1. Writes already made stay in
//   memory.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   start          one-cycle load request, honoured only in IDLE or DONE
//   load_count     instructions to load, latched when start is accepted
//   byte_in        stream byte
//   byte_valid     byte_in is valid this cycle
//   byte_ready     loader takes a byte this cycle
//   wr_en          memory write strobe, one cycle per instruction
//   wr_addr        write byte address (multiple of 4), held between writes
//   wr_data        instruction word, held between writes
//   busy           load in progress
//   done           load finished (level until the next accepted start)
//   error          load aborted or failed (same lifetime as done)
//   instr_written  instructions written in the current load
//
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
// byte_ready depends only on the loader state, never on byte_valid, and the
// source may hold byte_valid low for as long as it likes.
// -----------------------------------------------------------------------------
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_mem_loader #(
  parameter int MEM_WORDS = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           load_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [`WORD-1:0]      wr_addr,
  output logic [`INSTR_LEN-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           instr_written
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd4,
`endif
    S_DONE    = 3'd3
  } state_t;

  // Current state is kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_d;

  logic [15:0] count_q;     // latched load_count
  logic [1:0]  byte_cnt;    // bytes of the current word already received
  logic [23:0] shreg;       // first three bytes of the current word
  logic [15:0] written_inc;
  logic        xfer;
  logic        start_ok;
  logic        lc_zero;
  logic        lc_over;
  logic        last_write;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  localparam state_t S_AFTER_LAST = S_CHECK;
`else
  localparam state_t S_AFTER_LAST = S_DONE;
`endif

  assign xfer        = byte_valid && byte_ready;
  assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
  assign lc_zero     = (load_count == 16'd0);
  assign lc_over     = ({1'b0, load_count} > 17'(MEM_WORDS));
  assign written_inc = instr_written + 16'd1;
  assign last_write  = (written_inc == count_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d    = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (lc_zero || lc_over) state_d = S_DONE;
          else                    state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer && (byte_cnt == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (last_write) state_d = S_AFTER_LAST;
        else            state_d = S_COLLECT;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      byte_cnt      <= '0;
      shreg         <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      instr_written <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      if (start_ok) begin
        count_q       <= load_count;
        byte_cnt      <= '0;
        instr_written <= '0;
        // Zero-length and oversized loads finish immediately.
        done          <= lc_zero || lc_over;
        error         <= lc_over;
`ifdef LOADER_CHECKSUM_EN
        csum          <= '0;
`endif
      end

      if ((state == S_COLLECT) && xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        shreg    <= {shreg[15:0], byte_in};
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum + byte_in;
`endif
        // On the 4th byte present the word and its address during the
        // following WRITE cycle; both then hold until the next write.
        if (byte_cnt == 2'd3) begin
          wr_data <= {shreg, byte_in};
          wr_addr <= `WORD'(BASE_ADDR) + `WORD'({instr_written, 2'b00});
        end
      end

      if (state == S_WRITE) begin
        if (instr_written != count_q) instr_written <= written_inc;
`ifndef LOADER_CHECKSUM_EN
        if (last_write) done <= 1'b1;
`endif
      end

`ifdef LOADER_CHECKSUM_EN
      if ((state == S_CHECK) && xfer) begin
        done  <= 1'b1;
        error <= (byte_in != csum);
      end
`endif
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_instr_mem_loader;

  localparam int MEM_WORDS = 1024;
  localparam int BASE_ADDR = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                  start;
  logic [15:0]           load_count;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  wr_en;
  logic [`WORD-1:0]      wr_addr;
  logic [`INSTR_LEN-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [15:0]           instr_written;

  instr_mem_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .load_count(load_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .error(error), .instr_written(instr_written)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];          // {addr, data} of each expected write
  logic [31:0] load_words[$];     // words of the load being driven

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {wr_addr, wr_data}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [15:0] n);
    load_count = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Idle gap; pulses start with junk load_count, which a busy loader ignores.
  task automatic gap(input int cycles);
    for (int g = 0; g < cycles; g++) begin
      byte_valid = 1'b0;
      start = 1'($urandom_range(0, 1));
      load_count = 16'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    check("byte_accepted", 64'(ok), 64'd1);
  endtask

  // Four bytes, MSB first, then the write must appear in the very next cycle
  // with byte_ready low (the bubble).
  task automatic send_word(input logic [31:0] w, input int min_gap, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      gap($urandom_range(min_gap, max_gap));
      send_byte(8'((w >> (8 * (3 - k))) & 32'hFF));
    end
    @(negedge clk);
    check("write_latency_wr_en", 64'(wr_en), 64'd1);
    check("write_bubble_ready", 64'(byte_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input int min_gap, input int max_gap, input bit bad_csum);
    int n;
    bit exp_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'd0;
`endif
    n = load_words.size();
    exp_err = 1'b0;
    for (int i = 0; i < n; i++)
      exp_q.push_back({32'(BASE_ADDR + 4 * i), load_words[i]});
    do_start(16'(n));
    for (int i = 0; i < n; i++) begin
      send_word(load_words[i], min_gap, max_gap);
`ifdef LOADER_CHECKSUM_EN
      for (int k = 0; k < 4; k++) sum = sum + 8'((load_words[i] >> (8 * k)) & 32'hFF);
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (sum ^ 8'h01) : sum);
    exp_err = bad_csum;
`endif
    @(negedge clk);
    check("end_done", 64'(done), 64'd1);
    check("end_error", 64'(error), 64'(exp_err));
    check("end_busy", 64'(busy), 64'd0);
    check("end_instr_written", 64'(instr_written), 64'(n));
    check("end_addr_held", 64'(wr_addr), 64'(BASE_ADDR + 4 * (n - 1)));
    check("end_all_writes_seen", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_instr_written"}, 64'(instr_written), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    @(posedge clk); #1;
  endtask

  // Safety net if something stalls the stimulus entirely.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; load_count = '0; byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("reset");

    // Directed two-instruction load, no gaps.
    load_words = '{32'hD2800020, 32'h8B010000};
    run_load(0, 0, 1'b0);

    // Bytes offered in DONE are refused.
    byte_in = 8'hAA; byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_refuses_byte", 64'(byte_ready), 64'd0);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;

    // One instruction, byte_valid toggling every other cycle.
    load_words = '{32'hD2800020};
    run_load(1, 1, 1'b0);

    // Zero-length load.
    do_start(16'd0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_error", 64'(error), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Oversized load.
    do_start(16'(MEM_WORDS + 1));
    @(negedge clk);
    check("over_done", 64'(done), 64'd1);
    check("over_error", 64'(error), 64'd1);
    check("over_ready", 64'(byte_ready), 64'd0);
    @(posedge clk); #1;
    gap(2);

    // Reset after 6 of 8 bytes: first write happened, second never does.
    exp_q.push_back({32'(BASE_ADDR), 32'h11223344});
    do_start(16'd2);
    send_word(32'h11223344, 0, 1);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_first_write_seen", 64'(exp_q.size()), 64'd0);
    check_all_zero("midreset");
    byte_in = 8'h77; byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 byte_valid = 1'b0;

    // Fresh load starts at the base address again.
    load_words = '{32'hCAFEF00D};
    run_load(0, 1, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      load_words = {};
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) load_words.push_back($urandom);
      run_load(0, 2, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    load_words = '{32'h01020304};
    run_load(0, 0, 1'b0);
    run_load(0, 0, 1'b1);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
